// File: rtl/ripple_count_capture_pkg.sv
// Shared constants for the SN74-family capture logic: count width, filter FSM
// state encodings and a small modulo helper.
package ripple_count_capture_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned EVT_W = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Filter FSM encodings, kept as plain constants for compatibility with
  // older blocks that compare raw state bits.
  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HOLD   = 1'b1;

  // Successor of a count value; the 4-bit add wraps 15 -> 0 by itself.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] v);
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/ripple_count_capture_if.sv
// Signal bundle between a ripple-counter source and its capture stage.
// The master drives the raw count and the error clear; the slave publishes the settled view.
interface ripple_count_capture_if;
  import ripple_count_capture_pkg::*;

  logic [CNT_W-1:0] cnt;
  logic             clr;
  logic [CNT_W-1:0] q;
  logic             valid;
  logic             chg;
  logic             wrap;
  logic             skip;
  logic             err;
  logic [EVT_W-1:0] evt;

  modport master (
    output cnt, clr,
    input  q, valid, chg, wrap, skip, err, evt
  );

  modport slave (
    input  cnt, clr,
    output q, valid, chg, wrap, skip, err, evt
  );

endinterface

// File: rtl/ripple_count_capture_sync2.sv
// Width-parameterized two-flop synchronizer for asynchronous TTL-model outputs.
// The first stage feeds only the second stage, so metastability has a full cycle to resolve.
module ripple_count_capture_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/ripple_count_capture.sv
// Capture stage behind an SN74XX93 ripple counter: synchronizes the raw count, waits for it
// to settle, and publishes the accepted value with change/wrap/skip pulses and an event count.
module ripple_count_capture
  import ripple_count_capture_pkg::*;
#(
  parameter int unsigned STABLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  ripple_count_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(STABLE - 1);

  logic [CNT_W-1:0] s2;
  logic [0:0]       state;
  logic [CNT_W-1:0] cand;
  logic [CNT_W-1:0] run;

  logic [CNT_W-1:0] q_r;
  logic             valid_r;
  logic             chg_r;
  logic             wrap_r;
  logic             skip_r;
  logic             err_r;
  logic [EVT_W-1:0] evt_r;

  logic accept;
  logic upd;
  logic wrap_n;
  logic skip_n;

  ripple_count_capture_sync2 #(
    .WIDTH (CNT_W)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.cnt),
    .q   (s2)
  );

  // NOTE: every signal written here gets a default first, so no path can leave
  // a previous value implied and infer a latch.
  always_comb begin
    accept = 1'b0;
    upd    = 1'b0;
    wrap_n = 1'b0;
    skip_n = 1'b0;
    if (state == ST_SETTLE && s2 == cand && run == RUN_LAST) begin
      accept = 1'b1;
    end
    if (accept) begin
      if (!valid_r) begin
        upd = 1'b1;
      end else if (cand != q_r) begin
        upd    = 1'b1;
        wrap_n = (q_r == CNT_MAX) && (cand == '0);
        skip_n = (cand != next_cnt(q_r));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_SETTLE;
      cand    <= '0;
      run     <= '0;
      q_r     <= '0;
      valid_r <= 1'b0;
      chg_r   <= 1'b0;
      wrap_r  <= 1'b0;
      skip_r  <= 1'b0;
      err_r   <= 1'b0;
      evt_r   <= '0;
    end else begin
      // Any movement at s2 restarts the settle window, even from HOLD.
      if (s2 != cand) begin
        cand  <= s2;
        run   <= '0;
        state <= ST_SETTLE;
      end else if (state == ST_SETTLE) begin
        if (run == RUN_LAST) begin
          state <= ST_HOLD;
        end else begin
          run <= run + 1'b1;
        end
      end

      chg_r  <= upd;
      wrap_r <= wrap_n;
      skip_r <= skip_n;
      // A skip landing in the same cycle as clr must still be recorded.
      err_r  <= skip_n | (err_r & ~bus.clr);

      if (upd) begin
        q_r     <= cand;
        valid_r <= 1'b1;
        evt_r   <= evt_r + 1'b1;
      end
    end
  end

  assign bus.q     = q_r;
  assign bus.valid = valid_r;
  assign bus.chg   = chg_r;
  assign bus.wrap  = wrap_r;
  assign bus.skip  = skip_r;
  assign bus.err   = err_r;
  assign bus.evt   = evt_r;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Bench for ripple_count_capture: directed scenarios plus a randomized phase, all
// compared each cycle against a streak-based reference model of the settle rule.
module tb_ripple_count_capture;

  localparam int unsigned STABLE = 2;

  logic clk;
  logic rst;

  ripple_count_capture_if bus ();

  ripple_count_capture #(
    .STABLE (STABLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a value is accepted once the synchronized sample has been
  // identical on STABLE+1 consecutive edges (the reset edge counts as seeing 0).
  logic [3:0] m_p1, m_p2;
  logic [3:0] m_sval;
  int         m_streak;
  logic [3:0] m_q;
  logic       m_valid, m_chg, m_wrap, m_skip, m_err;
  logic [7:0] m_evt;

  int n_chg;
  int n_skip;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic model_edge();
    logic [3:0] pre;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_sval = '0; m_streak = 1;
      m_q = '0; m_valid = 0; m_chg = 0; m_wrap = 0; m_skip = 0; m_err = 0; m_evt = '0;
    end else begin
      pre = m_p2;
      if (pre == m_sval) begin
        if (m_streak < 1000) m_streak++;
      end else begin
        m_sval   = pre;
        m_streak = 1;
      end
      m_chg = 0; m_wrap = 0; m_skip = 0;
      if (m_streak == STABLE + 1) begin
        if (!m_valid) begin
          m_q = m_sval; m_valid = 1; m_chg = 1; m_evt = m_evt + 8'd1;
        end else if (m_sval != m_q) begin
          m_wrap = (m_q == 4'd15) && (m_sval == 4'd0);
          m_skip = (int'(m_sval) != (int'(m_q) + 1) % 16);
          m_chg  = 1;
          m_q    = m_sval;
          m_evt  = m_evt + 8'd1;
        end
      end
      if (m_skip) m_err = 1;
      else if (bus.clr) m_err = 0;
      m_p2 = m_p1;
      m_p1 = bus.cnt;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("q",     8'(bus.q),     8'(m_q));
    check("valid", 8'(bus.valid), 8'(m_valid));
    check("chg",   8'(bus.chg),   8'(m_chg));
    check("wrap",  8'(bus.wrap),  8'(m_wrap));
    check("skip",  8'(bus.skip),  8'(m_skip));
    check("err",   8'(bus.err),   8'(m_err));
    check("evt",   bus.evt,       m_evt);
    if (bus.chg)  n_chg++;
    if (bus.skip) n_skip++;
  endtask

  task automatic hold(input logic [3:0] c, input int n);
    bus.cnt = c;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_chg(input string tag, input int max, output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      n++;
      if (bus.chg) seen = 1;
    end
    check({tag, "_chg_seen"}, 8'(seen), 8'd1);
  endtask

  task automatic walk_to(input logic [3:0] target);
    for (int i = 0; i < 16 && m_q != target; i++) hold(m_q + 4'd1, STABLE + 4);
    check("walk_to", 8'(bus.q), 8'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] base;
    int r;

    rst = 1'b1; bus.cnt = 4'd0; bus.clr = 1'b0;
    m_p1 = '0; m_p2 = '0; m_sval = '0; m_streak = 1;
    m_q = '0; m_valid = 0; m_chg = 0; m_wrap = 0; m_skip = 0; m_err = 0; m_evt = '0;
    n_chg = 0; n_skip = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    check("rst_valid", 8'(bus.valid), 8'd0);
    check("rst_evt", bus.evt, 8'd0);

    // Scenario 1: release reset with 0 held, first acquisition.
    rst = 1'b0;
    n_chg = 0;
    hold(4'd0, 8);
    check("s1_valid", 8'(bus.valid), 8'd1);
    check("s1_q", 8'(bus.q), 8'd0);
    check("s1_evt", bus.evt, 8'd1);
    check("s1_nchg", 8'(n_chg), 8'd1);

    // Scenario 2: 3 -> 4 appears five edges after the change.
    walk_to(4'd3);
    bus.cnt = 4'd4;
    n_skip = 0;
    wait_chg("s2", 12, n);
    check("s2_latency", 8'(n), 8'(STABLE + 3));
    check("s2_q", 8'(bus.q), 8'd4);
    check("s2_skip", 8'(bus.skip), 8'd0);
    check("s2_evt", bus.evt, 8'd5);

    // Scenario 3: 15 -> 0 wraps without a skip.
    walk_to(4'd15);
    bus.cnt = 4'd0;
    wait_chg("s3", 12, n);
    check("s3_wrap", 8'(bus.wrap), 8'd1);
    check("s3_skip", 8'(bus.skip), 8'd0);
    check("s3_q", 8'(bus.q), 8'd0);

    // Scenario 4: ripple transients 7,6,4,0 then 8 give one clean accept.
    walk_to(4'd7);
    hold(4'd7, 4);
    n_chg = 0; n_skip = 0;
    hold(4'd6, 1);
    hold(4'd4, 1);
    hold(4'd0, 1);
    hold(4'd8, 10);
    check("s4_nchg", 8'(n_chg), 8'd1);
    check("s4_q", 8'(bus.q), 8'd8);
    check("s4_nskip", 8'(n_skip), 8'd0);

    // Scenario 5: skip sets err, clr clears it, skip with clr keeps it set.
    walk_to(4'd5);
    bus.cnt = 4'd9;
    wait_chg("s5a", 12, n);
    check("s5_skip", 8'(bus.skip), 8'd1);
    check("s5_err", 8'(bus.err), 8'd1);
    hold(4'd9, 4);
    check("s5_err_sticky", 8'(bus.err), 8'd1);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check("s5_err_clr", 8'(bus.err), 8'd0);
    bus.clr = 1'b1;
    bus.cnt = 4'd2;
    wait_chg("s5b", 12, n);
    bus.clr = 1'b0;
    check("s5_skip2", 8'(bus.skip), 8'd1);
    check("s5_err_setwins", 8'(bus.err), 8'd1);
    hold(4'd2, 4);

    // Scenario 6: reset two cycles into a 2 -> 3 settle discards it.
    n_chg = 0;
    hold(4'd3, 2);
    rst = 1'b1;
    step();
    check("s6_q", 8'(bus.q), 8'd0);
    check("s6_valid", 8'(bus.valid), 8'd0);
    check("s6_err", 8'(bus.err), 8'd0);
    check("s6_evt", bus.evt, 8'd0);
    check("s6_nchg", 8'(n_chg), 8'd0);
    bus.cnt = 4'd0;
    step();
    rst = 1'b0;
    hold(4'd0, 8);
    check("s6_reacq_valid", 8'(bus.valid), 8'd1);
    check("s6_reacq_evt", bus.evt, 8'd1);

    // Toggling every cycle never settles.
    n_chg = 0;
    for (int i = 0; i < 20; i++) hold((i % 2 == 0) ? 4'd5 : 4'd10, 1);
    check("toggle_nchg", 8'(n_chg), 8'd0);
    hold(4'd0, 6);

    // Randomized phase: counting, jumps, one-cycle glitches, clr and rare resets.
    base = m_q;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 19));
      bus.clr = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      if (r < 12) bus.cnt = base;
      else if (r < 16) begin base = base + 4'd1; bus.cnt = base; end
      else if (r < 17) begin base = 4'($urandom_range(0, 15)); bus.cnt = base; end
      else bus.cnt = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0; bus.clr = 1'b0;
    hold(base, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
